// File: rtl/conv2d_pkg.sv
// Shared constants for the conv2d_6x6 datapath: pixel width, default image
// size, 3x3 tap indices (row-major) and window-generator state encodings.
package conv2d_pkg;

  localparam int unsigned DW        = 16;  // signed Q8.8 pixel
  localparam int unsigned IMG_W_DEF = 6;
  localparam int unsigned IMG_H_DEF = 6;
  localparam int unsigned NTAPS     = 9;

  // Tap indices, row-major: TL = oldest row/oldest column, BR = newest pixel
  localparam int unsigned TAP_TL = 0;
  localparam int unsigned TAP_TC = 1;
  localparam int unsigned TAP_TR = 2;
  localparam int unsigned TAP_ML = 3;
  localparam int unsigned TAP_MC = 4;
  localparam int unsigned TAP_MR = 5;
  localparam int unsigned TAP_BL = 6;
  localparam int unsigned TAP_BC = 7;
  localparam int unsigned TAP_BR = 8;

  localparam logic [0:0] ST_FILL   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  typedef logic [DW-1:0] pix_t;

endpackage

// File: rtl/conv_window_gen_if.sv
// Pixel-in / window-out bus of conv_window_gen.
// Pixel side : i_valid, o_ready, i_data
// Window side: o_valid, i_ready, o_d0..o_d8 (row-major taps)
//              o_last only when CONV_WINDOW_LAST_EN is defined.
// slave = the window generator, master = whoever drives pixels / takes windows.
interface conv_window_gen_if;
  import conv2d_pkg::*;

  logic i_valid;
  logic o_ready;
  pix_t i_data;
  logic o_valid;
  logic i_ready;
  pix_t o_d0, o_d1, o_d2, o_d3, o_d4, o_d5, o_d6, o_d7, o_d8;
`ifdef CONV_WINDOW_LAST_EN
  logic o_last;
`endif

  modport slave (
    input  i_valid, i_data, i_ready,
    output o_ready, o_valid,
    output o_d0, o_d1, o_d2, o_d3, o_d4, o_d5, o_d6, o_d7, o_d8
`ifdef CONV_WINDOW_LAST_EN
    , output o_last
`endif
  );

  modport master (
    output i_valid, i_data, i_ready,
    input  o_ready, o_valid,
    input  o_d0, o_d1, o_d2, o_d3, o_d4, o_d5, o_d6, o_d7, o_d8
`ifdef CONV_WINDOW_LAST_EN
    , input o_last
`endif
  );

endinterface

// File: rtl/conv_line_buffer.sv
// DEPTH-deep, W-wide shift register advancing only when i_en is high.
// Ports: i_clk, i_en (shift), i_data (word in),
//        o_tail_c (oldest word, i.e. the one displaced by the next shift).
// Contents are not reset; the consumer never uses stale words.
module conv_line_buffer #(
  parameter int unsigned DEPTH = 6,
  parameter int unsigned W     = 16
) (
  input  logic         i_clk,
  input  logic         i_en,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_tail_c
);

  logic [DEPTH*W-1:0] r_mem;

  always_ff @(posedge i_clk) begin
    if (i_en) r_mem <= {r_mem[(DEPTH-1)*W-1:0], i_data};
  end

  assign o_tail_c = r_mem[DEPTH*W-1 -: W];

endmodule

// File: rtl/conv_window_gen.sv
// Streaming 3x3 window generator (valid convolution, no padding).
// Takes a raster-ordered pixel stream and emits each fully populated 3x3
// window as nine parallel taps, one cycle after the pixel that completes it.
// Ports: i_clk, i_rst (sync, active-high), bus (conv_window_gen_if.slave).
// Optional macro CONV_WINDOW_LAST_EN adds bus.o_last marking the final
// window of each frame.
module conv_window_gen
  import conv2d_pkg::*;
#(
  parameter int unsigned IMG_W = IMG_W_DEF,
  parameter int unsigned IMG_H = IMG_H_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  conv_window_gen_if.slave  bus
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);

  logic [CW-1:0] r_col, w_col_nxt;
  logic [RW-1:0] r_row, w_row_nxt;
  logic [0:0]    r_state, w_state_nxt;

  pix_t r_c0 [3];       // two older window columns, index 0 = top row
  pix_t r_c1 [3];
  pix_t r_d  [NTAPS];
  logic r_valid;
  logic r_last;

  pix_t w_lb0, w_lb1;
  logic w_accept, w_col_wrap, w_row_last, w_load;

  assign bus.o_ready = !r_valid || bus.i_ready;
  assign w_accept    = bus.i_valid && bus.o_ready;
  assign w_col_wrap  = (r_col == CW'(IMG_W - 1));
  assign w_row_last  = (r_row == RW'(IMG_H - 1));
  assign w_load      = w_accept && (r_state == ST_STREAM) && (r_col >= CW'(2));

  // Line buffers hold the two previous rows; lb0 feeds lb1 with its displaced word
  conv_line_buffer #(.DEPTH(IMG_W), .W(DW)) u_lb0 (
    .i_clk    (i_clk),
    .i_en     (w_accept),
    .i_data   (bus.i_data),
    .o_tail_c (w_lb0)
  );

  conv_line_buffer #(.DEPTH(IMG_W), .W(DW)) u_lb1 (
    .i_clk    (i_clk),
    .i_en     (w_accept),
    .i_data   (w_lb0),
    .o_tail_c (w_lb1)
  );

  // State and counter register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_FILL;
      r_col   <= '0;
      r_row   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_col   <= w_col_nxt;
      r_row   <= w_row_nxt;
    end
  end

  // Next state / raster counters
  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    w_row_nxt   = r_row;
    if (w_accept) begin
      if (w_col_wrap) begin
        w_col_nxt = '0;
        w_row_nxt = w_row_last ? '0 : r_row + RW'(1);
      end else begin
        w_col_nxt = r_col + CW'(1);
      end
      case (r_state)
        ST_FILL:   if (w_col_wrap && (r_row == RW'(1))) w_state_nxt = ST_STREAM;
        ST_STREAM: if (w_col_wrap && w_row_last)        w_state_nxt = ST_FILL;
        default:   w_state_nxt = ST_FILL;
      endcase
    end
  end

  // Window history: shift in the column {two rows up, one row up, new pixel}
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_c0[0] <= r_c1[0];
      r_c0[1] <= r_c1[1];
      r_c0[2] <= r_c1[2];
      r_c1[0] <= w_lb1;
      r_c1[1] <= w_lb0;
      r_c1[2] <= bus.i_data;
    end
  end

  // Output register; a load during a transfer replaces the window bubble-free
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      for (int unsigned i = 0; i < NTAPS; i++) r_d[i] <= '0;
    end else if (w_load) begin
      r_valid   <= 1'b1;
      r_last    <= w_col_wrap && w_row_last;
      r_d[TAP_TL] <= r_c0[0];
      r_d[TAP_TC] <= r_c1[0];
      r_d[TAP_TR] <= w_lb1;
      r_d[TAP_ML] <= r_c0[1];
      r_d[TAP_MC] <= r_c1[1];
      r_d[TAP_MR] <= w_lb0;
      r_d[TAP_BL] <= r_c0[2];
      r_d[TAP_BC] <= r_c1[2];
      r_d[TAP_BR] <= bus.i_data;
    end else if (bus.i_ready) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end
  end

  assign bus.o_valid = r_valid;
  assign bus.o_d0    = r_d[TAP_TL];
  assign bus.o_d1    = r_d[TAP_TC];
  assign bus.o_d2    = r_d[TAP_TR];
  assign bus.o_d3    = r_d[TAP_ML];
  assign bus.o_d4    = r_d[TAP_MC];
  assign bus.o_d5    = r_d[TAP_MR];
  assign bus.o_d6    = r_d[TAP_BL];
  assign bus.o_d7    = r_d[TAP_BC];
  assign bus.o_d8    = r_d[TAP_BR];
`ifdef CONV_WINDOW_LAST_EN
  assign bus.o_last  = r_last;
`else
  logic w_unused;
  assign w_unused = r_last;
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen at 6x6: expected windows are queued
// as pixels are issued, a monitor pops and compares on every transfer.
module tb_conv_window_gen;

  localparam int W = 6;
  localparam int H = 6;

  typedef struct packed {
    logic             last;
    logic [8:0][15:0] d;
  } win_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_window_gen_if bus();

  conv_window_gen #(.IMG_W(W), .IMG_H(H)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  int   n_xfer   = 0;
  int   rdy_mode = 0;   // 0: always ready, 1: random, 2: stall 5 cycles after 3rd window
  int   stall_cnt = 0;
  win_t q[$];
  win_t rx[$];
  win_t snap;

  function automatic win_t mk_win(input int base, input int r, input int c);
    win_t w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w.d[3*i+j] = 16'((base + (r - 2 + i) * W + (c - 2 + j)) * 256);
`ifdef CONV_WINDOW_LAST_EN
    w.last = (r == H - 1) && (c == W - 1);
`endif
    return w;
  endfunction

  function automatic win_t cur_win();
    win_t g;
    g = '0;
    g.d[0] = bus.o_d0; g.d[1] = bus.o_d1; g.d[2] = bus.o_d2;
    g.d[3] = bus.o_d3; g.d[4] = bus.o_d4; g.d[5] = bus.o_d5;
    g.d[6] = bus.o_d6; g.d[7] = bus.o_d7; g.d[8] = bus.o_d8;
`ifdef CONV_WINDOW_LAST_EN
    g.last = bus.o_last;
`endif
    return g;
  endfunction

  task automatic check(input string name, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: pop and compare whenever a window transfers on the next edge
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.o_valid && bus.i_ready) begin
        win_t g;
        g = cur_win();
        rx.push_back(g);
        n_xfer++;
        n_checks++;
        if (q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_window #%0d: got %h expected none", n_xfer, g);
        end else begin
          win_t e;
          e = q.pop_front();
          if (g !== e) begin
            n_errors++;
            $display("FAIL window #%0d: got %h expected %h", n_xfer, g, e);
          end
        end
      end
    end
  end

  // Downstream ready driver
  initial begin
    bus.i_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1: bus.i_ready = 1'($urandom_range(1));
        2: if (n_xfer == 3 && stall_cnt < 5) begin
             bus.i_ready = 1'b0;
             stall_cnt++;
           end else bus.i_ready = 1'b1;
        default: bus.i_ready = 1'b1;
      endcase
    end
  end

  // Stall checker: taps hold and o_ready stays low while stalled
  initial begin
    forever begin
      @(negedge clk);
      if (rdy_mode == 2 && !bus.i_ready) begin
        check("stall_o_ready", 160'(bus.o_ready), 160'(1'b0));
        check("stall_o_valid", 160'(bus.o_valid), 160'(1'b1));
        if (stall_cnt == 1) snap = cur_win();
        else check("stall_hold", 160'(cur_win()), 160'(snap));
      end
    end
  end

  // Watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [15:0] v, input bit gaps);
    logic acc;
    if (gaps) begin
      while ($urandom_range(1) == 0) begin
        bus.i_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    bus.i_valid = 1'b1;
    bus.i_data  = v;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      acc = bus.o_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      if (t > 1000) begin
        check("accept_timeout", 160'(1'b0), 160'(1'b1));
        break;
      end
    end
    bus.i_valid = 1'b0;
  endtask

  task automatic send_frame(input int base, input bit gaps, input bit chk_first, input int npix);
    logic [8:0][15:0] first_exp;
    first_exp = {16'h0E00, 16'h0D00, 16'h0C00, 16'h0800, 16'h0700,
                 16'h0600, 16'h0200, 16'h0100, 16'h0000};
    for (int k = 0; k < npix; k++) begin
      int r, c;
      r = k / W;
      c = k % W;
      if (r >= 2 && c >= 2) q.push_back(mk_win(base, r, c));
      send(16'((base + k) * 256), gaps);
      if (chk_first && k == 14) begin
        win_t g;
        g = cur_win();
        check("first_window_valid", 160'(bus.o_valid), 160'(1'b1));
        check("first_window_taps", 160'(g.d), 160'(first_exp));
      end
    end
  endtask

  task automatic drain(input int exp_cnt);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 500; t++) begin
      if (q.size() == 0 && !bus.o_valid) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("drain", 160'(ok), 160'(1'b1));
    check("window_count", 160'(n_xfer), 160'(exp_cnt));
  endtask

  initial begin
    rst = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_o_valid", 160'(bus.o_valid), 160'(1'b0));
    check("reset_taps", 160'(cur_win()), 160'(0));
    check("reset_o_ready", 160'(bus.o_ready), 160'(1'b1));
    @(posedge clk);
    #1;

    // Single frame, always ready
    n_xfer = 0; rx.delete();
    send_frame(0, 1'b0, 1'b1, W * H);
    drain(16);
    if (rx.size() == 16) begin
      check("last_window_d0", 160'(rx[15].d[0]), 160'(16'h1500));
      check("last_window_d8", 160'(rx[15].d[8]), 160'(16'h2300));
    end

    // Single frame with a 5-cycle stall after the 3rd window
    n_xfer = 0; rx.delete(); stall_cnt = 0; rdy_mode = 2;
    send_frame(0, 1'b0, 1'b0, W * H);
    drain(16);
    check("stall_cycles", 160'(stall_cnt), 160'(5));
    rdy_mode = 0;

    // Two back-to-back frames
    n_xfer = 0; rx.delete();
    send_frame(0, 1'b0, 1'b0, W * H);
    send_frame(100, 1'b0, 1'b0, W * H);
    drain(32);
    if (rx.size() == 32) begin
      bit mixed;
      int nlast;
      mixed = 1'b0;
      nlast = 0;
      check("frame2_first_d0", 160'(rx[16].d[0]), 160'(16'h6400));
      check("frame2_first_d8", 160'(rx[16].d[8]), 160'(16'h7200));
      foreach (rx[i]) begin
        bit lo, hi;
        lo = 1'b1; hi = 1'b1;
        for (int t = 0; t < 9; t++) begin
          if (rx[i].d[t] >= 16'h2400) lo = 1'b0;
          if (rx[i].d[t] <  16'h6400) hi = 1'b0;
        end
        if (!lo && !hi) mixed = 1'b1;
        if (rx[i].last) nlast++;
      end
      check("no_frame_mixing", 160'(mixed), 160'(1'b0));
`ifdef CONV_WINDOW_LAST_EN
      check("last_count", 160'(nlast), 160'(2));
      check("last_on_16", 160'(rx[15].last), 160'(1'b1));
      check("last_on_32", 160'(rx[31].last), 160'(1'b1));
`else
      check("last_count", 160'(nlast), 160'(0));
`endif
    end

    // Reset after 20 pixels, then a clean frame
    n_xfer = 0; rx.delete();
    send_frame(0, 1'b0, 1'b0, 20);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("post_reset_o_valid", 160'(bus.o_valid), 160'(1'b0));
    check("post_reset_queue", 160'(q.size()), 160'(0));
    check("partial_window_count", 160'(n_xfer), 160'(4));
    n_xfer = 0; rx.delete();
    send_frame(0, 1'b0, 1'b1, W * H);
    drain(16);

    // Random input gaps and random downstream ready, two frames
    n_xfer = 0; rx.delete(); rdy_mode = 1;
    send_frame(40, 1'b1, 1'b0, W * H);
    send_frame(140, 1'b1, 1'b0, W * H);
    rdy_mode = 0;
    drain(32);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
